// File: rtl/mesh_resource_ni_if.sv
// Resource-port bundle of a mesh network interface: resource TX/RX handshakes,
// switch injection/ejection handshakes and the statistics counters.
interface mesh_resource_ni_if #(
   parameter int PCKT_XADDR_W = 4,
   parameter int PCKT_YADDR_W = 4,
   parameter int PCKT_DATA_W  = 8,
   parameter int PCKT_W       = PCKT_XADDR_W + PCKT_YADDR_W + PCKT_DATA_W
);
   logic                    tx_valid_i;
   logic [PCKT_XADDR_W-1:0] tx_x_i;
   logic [PCKT_YADDR_W-1:0] tx_y_i;
   logic [PCKT_DATA_W-1:0]  tx_data_i;
   logic                    tx_ready_o;
   logic                    sw_wr_en_o;
   logic [PCKT_W-1:0]       sw_pckt_o;
   logic                    sw_full_i;
   logic                    sw_wr_en_i;
   logic [PCKT_W-1:0]       sw_pckt_i;
   logic                    sw_full_o;
   logic                    sw_overflow_o;
   logic                    rx_valid_o;
   logic [PCKT_DATA_W-1:0]  rx_data_o;
   logic                    rx_ready_i;
   logic                    misroute_o;
   logic [15:0]             stat_tx_cnt_o;
   logic [15:0]             stat_rx_cnt_o;
   logic [15:0]             stat_drop_cnt_o;

   modport slave (
      input  tx_valid_i, tx_x_i, tx_y_i, tx_data_i, sw_full_i, sw_wr_en_i, sw_pckt_i, rx_ready_i,
      output tx_ready_o, sw_wr_en_o, sw_pckt_o, sw_full_o, sw_overflow_o, rx_valid_o, rx_data_o,
             misroute_o, stat_tx_cnt_o, stat_rx_cnt_o, stat_drop_cnt_o
   );

   modport master (
      output tx_valid_i, tx_x_i, tx_y_i, tx_data_i, sw_full_i, sw_wr_en_i, sw_pckt_i, rx_ready_i,
      input  tx_ready_o, sw_wr_en_o, sw_pckt_o, sw_full_o, sw_overflow_o, rx_valid_o, rx_data_o,
             misroute_o, stat_tx_cnt_o, stat_rx_cnt_o, stat_drop_cnt_o
   );
endinterface

// File: rtl/mesh_resource_ni.sv
// Mesh node network interface: TX queue injecting into the XY switch, RX queue with address check.
// Define MESH_NI_STATS_EN to build the saturating tx/rx/drop packet counters (tied to 0 otherwise).
module mesh_resource_ni #(
   parameter int X_CORD          = 0,
   parameter int Y_CORD          = 0,
   parameter int PCKT_XADDR_W    = 4,
   parameter int PCKT_YADDR_W    = 4,
   parameter int PCKT_DATA_W     = 8,
   parameter int PCKT_W          = PCKT_XADDR_W + PCKT_YADDR_W + PCKT_DATA_W,
   parameter int TX_FIFO_DEPTH_W = 2,
   parameter int RX_FIFO_DEPTH_W = 3
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   mesh_resource_ni_if.slave  ni
);
   localparam int TXC_W = TX_FIFO_DEPTH_W + 1;
   localparam int RXC_W = RX_FIFO_DEPTH_W + 1;
   localparam int TX_DEPTH = 1 << TX_FIFO_DEPTH_W;
   localparam int RX_DEPTH = 1 << RX_FIFO_DEPTH_W;
   localparam logic [TXC_W-1:0] TX_FULL_CNT = TXC_W'(TX_DEPTH);
   localparam logic [RXC_W-1:0] RX_FULL_CNT = RXC_W'(RX_DEPTH);

   logic [PCKT_W-1:0]          tx_mem_q [TX_DEPTH];
   logic [PCKT_DATA_W-1:0]     rx_mem_q [RX_DEPTH];

   logic [TX_FIFO_DEPTH_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
   logic [TXC_W-1:0]           tx_count_q, tx_count_d;
   logic                       tx_ready_q, tx_ready_d;
   logic                       sw_wr_en_q, sw_wr_en_d;
   logic [PCKT_W-1:0]          sw_pckt_q, sw_pckt_d;
   logic [RX_FIFO_DEPTH_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
   logic [RXC_W-1:0]           rx_count_q, rx_count_d;
   logic                       sw_full_q, sw_full_d;
   logic                       overflow_q, overflow_d;
   logic                       misroute_q, misroute_d;

   logic tx_push, tx_pop, rx_push, rx_pop, rx_match, rx_full, rx_empty;

   always_comb begin
      tx_push     = ni.tx_valid_i && tx_ready_q;
      tx_pop      = (tx_count_q != '0) && !ni.sw_full_i;
      tx_count_d  = tx_count_q + TXC_W'(tx_push) - TXC_W'(tx_pop);
      tx_wr_ptr_d = tx_wr_ptr_q + TX_FIFO_DEPTH_W'(tx_push);
      tx_rd_ptr_d = tx_rd_ptr_q + TX_FIFO_DEPTH_W'(tx_pop);
      // Ready is registered from the next count, so a pop from a full queue cannot admit a push in the same cycle.
      tx_ready_d  = (tx_count_d != TX_FULL_CNT);
      sw_wr_en_d  = tx_pop;
      sw_pckt_d   = tx_pop ? tx_mem_q[tx_rd_ptr_q] : sw_pckt_q;

      rx_match    = (ni.sw_pckt_i[PCKT_W-1 -: PCKT_XADDR_W] == PCKT_XADDR_W'(X_CORD)) &&
                    (ni.sw_pckt_i[PCKT_DATA_W +: PCKT_YADDR_W] == PCKT_YADDR_W'(Y_CORD));
      rx_full     = (rx_count_q == RX_FULL_CNT);
      rx_empty    = (rx_count_q == '0);
      rx_pop      = ni.rx_ready_i && !rx_empty;
      // A pop in the same cycle frees the slot, so a full queue still takes the write.
      rx_push     = ni.sw_wr_en_i && rx_match && (!rx_full || rx_pop);
      overflow_d  = ni.sw_wr_en_i && rx_match && rx_full && !rx_pop;
      misroute_d  = ni.sw_wr_en_i && !rx_match;
      rx_count_d  = rx_count_q + RXC_W'(rx_push) - RXC_W'(rx_pop);
      rx_wr_ptr_d = rx_wr_ptr_q + RX_FIFO_DEPTH_W'(rx_push);
      rx_rd_ptr_d = rx_rd_ptr_q + RX_FIFO_DEPTH_W'(rx_pop);
      sw_full_d   = (rx_count_d == RX_FULL_CNT);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_wr_ptr_q <= '0;
         tx_rd_ptr_q <= '0;
         tx_count_q  <= '0;
         tx_ready_q  <= 1'b0;
         sw_wr_en_q  <= 1'b0;
         sw_pckt_q   <= '0;
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
         rx_count_q  <= '0;
         sw_full_q   <= 1'b0;
         overflow_q  <= 1'b0;
         misroute_q  <= 1'b0;
      end else begin
         tx_wr_ptr_q <= tx_wr_ptr_d;
         tx_rd_ptr_q <= tx_rd_ptr_d;
         tx_count_q  <= tx_count_d;
         tx_ready_q  <= tx_ready_d;
         sw_wr_en_q  <= sw_wr_en_d;
         sw_pckt_q   <= sw_pckt_d;
         rx_wr_ptr_q <= rx_wr_ptr_d;
         rx_rd_ptr_q <= rx_rd_ptr_d;
         rx_count_q  <= rx_count_d;
         sw_full_q   <= sw_full_d;
         overflow_q  <= overflow_d;
         misroute_q  <= misroute_d;
      end
   end

   // Queue storage carries no reset; validity is tracked purely by the pointers and counts.
   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem_q[tx_wr_ptr_q] <= {ni.tx_x_i, ni.tx_y_i, ni.tx_data_i};
      if (rx_push) rx_mem_q[rx_wr_ptr_q] <= ni.sw_pckt_i[PCKT_DATA_W-1:0];
   end

   assign ni.tx_ready_o    = tx_ready_q;
   assign ni.sw_wr_en_o    = sw_wr_en_q;
   assign ni.sw_pckt_o     = sw_pckt_q;
   assign ni.sw_full_o     = sw_full_q;
   assign ni.sw_overflow_o = overflow_q;
   assign ni.misroute_o    = misroute_q;
   assign ni.rx_valid_o    = !rx_empty;
   assign ni.rx_data_o     = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];

`ifdef MESH_NI_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
      return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

   logic [15:0] stat_tx_q, stat_tx_d, stat_rx_q, stat_rx_d, stat_drop_q, stat_drop_d;

   always_comb begin
      stat_tx_d   = sat_inc(stat_tx_q, tx_pop);
      stat_rx_d   = sat_inc(stat_rx_q, rx_push);
      stat_drop_d = sat_inc(stat_drop_q, overflow_d || misroute_d);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stat_tx_q   <= '0;
         stat_rx_q   <= '0;
         stat_drop_q <= '0;
      end else begin
         stat_tx_q   <= stat_tx_d;
         stat_rx_q   <= stat_rx_d;
         stat_drop_q <= stat_drop_d;
      end
   end

   assign ni.stat_tx_cnt_o   = stat_tx_q;
   assign ni.stat_rx_cnt_o   = stat_rx_q;
   assign ni.stat_drop_cnt_o = stat_drop_q;
`else
   assign ni.stat_tx_cnt_o   = '0;
   assign ni.stat_rx_cnt_o   = '0;
   assign ni.stat_drop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mesh_resource_ni.sv
// Directed bench for mesh_resource_ni at node (1,2): TX inject/backpressure, RX deliver/misroute/overflow, async reset.
module tb_mesh_resource_ni;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

`ifdef MESH_NI_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   mesh_resource_ni_if #(.PCKT_XADDR_W(4), .PCKT_YADDR_W(4), .PCKT_DATA_W(8)) ni_if ();

   mesh_resource_ni #(
      .X_CORD(1), .Y_CORD(2), .PCKT_XADDR_W(4), .PCKT_YADDR_W(4), .PCKT_DATA_W(8),
      .TX_FIFO_DEPTH_W(2), .RX_FIFO_DEPTH_W(3)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .ni     (ni_if.slave)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] stat_exp(input int n);
      return STATS ? 32'(n) : 32'd0;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_tx_ready"}, 32'(ni_if.tx_ready_o), 32'd0);
      check({tag, "_sw_wr_en"}, 32'(ni_if.sw_wr_en_o), 32'd0);
      check({tag, "_sw_pckt"},  32'(ni_if.sw_pckt_o),  32'd0);
      check({tag, "_sw_full"},  32'(ni_if.sw_full_o),  32'd0);
      check({tag, "_overflow"}, 32'(ni_if.sw_overflow_o), 32'd0);
      check({tag, "_rx_valid"}, 32'(ni_if.rx_valid_o), 32'd0);
      check({tag, "_rx_data"},  32'(ni_if.rx_data_o),  32'd0);
      check({tag, "_misroute"}, 32'(ni_if.misroute_o), 32'd0);
      check({tag, "_stat_tx"},  32'(ni_if.stat_tx_cnt_o),   32'd0);
      check({tag, "_stat_rx"},  32'(ni_if.stat_rx_cnt_o),   32'd0);
      check({tag, "_stat_drop"},32'(ni_if.stat_drop_cnt_o), 32'd0);
   endtask

   initial begin
      ni_if.tx_valid_i = 1'b0;
      ni_if.tx_x_i     = '0;
      ni_if.tx_y_i     = '0;
      ni_if.tx_data_i  = '0;
      ni_if.sw_full_i  = 1'b0;
      ni_if.sw_wr_en_i = 1'b0;
      ni_if.sw_pckt_i  = '0;
      ni_if.rx_ready_i = 1'b0;

      // Reset state
      step();
      step();
      check_idle_outputs("rst");
      rst_ni = 1'b1;
      step();
      check("ready_after_rst", 32'(ni_if.tx_ready_o), 32'd1);

      // Single TX packet: accept, then one strobe one cycle later
      ni_if.tx_valid_i = 1'b1; ni_if.tx_x_i = 4'h3; ni_if.tx_y_i = 4'h0; ni_if.tx_data_i = 8'hA5;
      step();
      ni_if.tx_valid_i = 1'b0;
      check("tx1_no_early_strobe", 32'(ni_if.sw_wr_en_o), 32'd0);
      step();
      check("tx1_strobe", 32'(ni_if.sw_wr_en_o), 32'd1);
      check("tx1_pckt",   32'(ni_if.sw_pckt_o),  32'h30A5);
      step();
      check("tx1_strobe_once", 32'(ni_if.sw_wr_en_o), 32'd0);
      check("tx1_pckt_hold",   32'(ni_if.sw_pckt_o),  32'h30A5);

      // Backpressure: 5 back-to-back pushes with switch full, only 4 accepted
      ni_if.sw_full_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ni_if.tx_valid_i = 1'b1; ni_if.tx_x_i = 4'h5; ni_if.tx_y_i = 4'h6; ni_if.tx_data_i = 8'(8'h10 + i);
         step();
         check($sformatf("bp_ready_%0d", i), 32'(ni_if.tx_ready_o), (i < 3) ? 32'd1 : 32'd0);
         check($sformatf("bp_stall_%0d", i), 32'(ni_if.sw_wr_en_o), 32'd0);
      end
      ni_if.tx_valid_i = 1'b0;
      ni_if.sw_full_i  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("bp_strobe_%0d", k), 32'(ni_if.sw_wr_en_o), 32'd1);
         check($sformatf("bp_pckt_%0d", k),   32'(ni_if.sw_pckt_o), 32'h5610 + 32'(k));
         check($sformatf("bp_ready_back_%0d", k), 32'(ni_if.tx_ready_o), 32'd1);
      end
      step();
      check("bp_no_extra_strobe", 32'(ni_if.sw_wr_en_o), 32'd0);
      check("stat_tx_5", 32'(ni_if.stat_tx_cnt_o), stat_exp(5));

      // RX good packet, then consume it
      ni_if.sw_wr_en_i = 1'b1; ni_if.sw_pckt_i = 16'h123C;
      step();
      ni_if.sw_wr_en_i = 1'b0;
      check("rx1_valid",    32'(ni_if.rx_valid_o), 32'd1);
      check("rx1_data",     32'(ni_if.rx_data_o),  32'h3C);
      check("rx1_misroute", 32'(ni_if.misroute_o), 32'd0);
      ni_if.rx_ready_i = 1'b1;
      step();
      check("rx1_consumed", 32'(ni_if.rx_valid_o), 32'd0);
      step();
      check("rx_underflow_ignored", 32'(ni_if.rx_valid_o), 32'd0);
      ni_if.rx_ready_i = 1'b0;

      // Misrouted packet
      ni_if.sw_wr_en_i = 1'b1; ni_if.sw_pckt_i = 16'h2277;
      step();
      ni_if.sw_wr_en_i = 1'b0;
      check("mis_pulse", 32'(ni_if.misroute_o), 32'd1);
      check("mis_no_valid", 32'(ni_if.rx_valid_o), 32'd0);
      check("mis_stat_drop", 32'(ni_if.stat_drop_cnt_o), stat_exp(1));
      step();
      check("mis_pulse_once", 32'(ni_if.misroute_o), 32'd0);

      // Fill the RX queue, overflow, then drain in order
      for (int i = 0; i < 8; i++) begin
         ni_if.sw_wr_en_i = 1'b1; ni_if.sw_pckt_i = 16'h1240 + 16'(i);
         step();
         check($sformatf("fill_full_%0d", i), 32'(ni_if.sw_full_o), (i == 7) ? 32'd1 : 32'd0);
      end
      ni_if.sw_pckt_i = 16'h12EE;
      step();
      ni_if.sw_wr_en_i = 1'b0;
      check("ovf_pulse", 32'(ni_if.sw_overflow_o), 32'd1);
      check("ovf_still_full", 32'(ni_if.sw_full_o), 32'd1);
      step();
      check("ovf_pulse_once", 32'(ni_if.sw_overflow_o), 32'd0);
      ni_if.rx_ready_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("drain_valid_%0d", k), 32'(ni_if.rx_valid_o), 32'd1);
         check($sformatf("drain_data_%0d", k),  32'(ni_if.rx_data_o), 32'h40 + 32'(k));
         step();
      end
      ni_if.rx_ready_i = 1'b0;
      check("drain_empty", 32'(ni_if.rx_valid_o), 32'd0);
      check("drain_not_full", 32'(ni_if.sw_full_o), 32'd0);
      check("stat_rx_9",   32'(ni_if.stat_rx_cnt_o),   stat_exp(9));
      check("stat_drop_2", 32'(ni_if.stat_drop_cnt_o), stat_exp(2));

      // Async reset with two packets in each queue
      ni_if.sw_full_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ni_if.tx_valid_i = 1'b1; ni_if.tx_x_i = 4'h7; ni_if.tx_y_i = 4'h7; ni_if.tx_data_i = 8'(i);
         ni_if.sw_wr_en_i = 1'b1; ni_if.sw_pckt_i = 16'h1290 + 16'(i);
         step();
      end
      ni_if.tx_valid_i = 1'b0;
      ni_if.sw_wr_en_i = 1'b0;
      check("pre_rst_rx_valid", 32'(ni_if.rx_valid_o), 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      check_idle_outputs("async_rst");
      step();
      ni_if.sw_full_i = 1'b0;
      #2;
      rst_ni = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("post_rst_no_strobe_%0d", k), 32'(ni_if.sw_wr_en_o), 32'd0);
         check($sformatf("post_rst_rx_empty_%0d", k),  32'(ni_if.rx_valid_o), 32'd0);
      end
      check("post_rst_ready", 32'(ni_if.tx_ready_o), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
